hdmi_tx_cfg_seq: RTL and testbench



---
 rtl/hdmi_tx_cfg_pkg.sv | 40 ++++
 rtl/hdmi_tx_cfg_seq_sync2.sv | 25 ++
 rtl/hdmi_tx_cfg_seq.sv | 190 +++++++++++++++++++
 tb/tb_hdmi_tx_cfg_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tx_cfg_pkg.sv
// Shared definitions for the HDMI transmitter register-initialisation sequencer:
// table size, FSM encoding and the bring-up register table.
package hdmi_tx_cfg_pkg;

  localparam int N_REGS = 12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ADDR,
    ST_REG,
    ST_DATA,
    ST_WAIT_RSP,
    ST_RETRY_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Bring-up table entry: {register, value}.
  function automatic logic [15:0] cfg_entry(input logic [5:0] idx);
    logic [15:0] e;
    case (idx)
      6'd0:    e = 16'h41_10;  // main power up
      6'd1:    e = 16'h98_03;  // fixed register
      6'd2:    e = 16'h9A_E0;  // fixed register
      6'd3:    e = 16'h9C_30;  // fixed register
      6'd4:    e = 16'h9D_61;  // fixed register
      6'd5:    e = 16'hA2_A4;  // fixed register
      6'd6:    e = 16'hA3_A4;  // fixed register
      6'd7:    e = 16'hE0_D0;  // fixed register
      6'd8:    e = 16'hF9_00;  // fixed I2C address register
      6'd9:    e = 16'h15_00;  // input ID: 24-bit RGB 4:4:4
      6'd10:   e = 16'h16_30;  // output 4:4:4, 8 bits per colour
      6'd11:   e = 16'hAF_06;  // HDMI (not DVI) mode
      default: e = 16'h00_00;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/hdmi_tx_cfg_seq_sync2.sv
// Two-flop synchronizer for the asynchronous hot-plug line.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Capture the async input, then re-register to settle metastability.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/hdmi_tx_cfg_seq.sv
// HDMI transmitter register-initialisation sequencer. Walks the bring-up table
// and writes each (register, value) pair as ADDR/REG/DATA bytes to an I2C
// master command port, retrying NACKed entries after a gap.
module hdmi_tx_cfg_seq
  import hdmi_tx_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter logic [23:0] WAIT_CYCLES = 24'd10_000_000,
  parameter logic [3:0]  RETRY_MAX   = 4'd3,
  parameter logic [15:0] RETRY_GAP   = 16'd5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_hpd,
  output logic       o_cmd_valid,
  output logic       o_cmd_start,
  output logic       o_cmd_stop,
  output logic [7:0] o_cmd_data,
  input  logic       i_cmd_ready,
  input  logic       i_rsp_valid,
  input  logic       i_rsp_nack,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [5:0] o_index
);

  localparam logic [23:0] SETTLE_LAST = WAIT_CYCLES - 24'd1;
  localparam logic [15:0] GAP_LAST    = RETRY_GAP - 16'd1;
  localparam logic [5:0]  LAST_IDX    = 6'(N_REGS - 1);

  state_e      state_q, state_d;
  state_e      byte_q, byte_d;     // byte state whose response is awaited
  logic [23:0] settle_q, settle_d;
  logic [15:0] gap_q, gap_d;
  logic [3:0]  retry_q, retry_d;
  logic [5:0]  idx_q, idx_d;
  logic        watch_q, watch_d;   // run was started with hpd high: supervise it
  logic        abort_q, abort_d;   // hpd lost while a byte was in flight
  logic        hpd_prev_q;

  logic        hpd_s;
  logic        idle_like;
  logic        trigger;
  logic        hpd_lost;
  logic [15:0] entry;
  logic [4:0]  retry_inc;

  sync2 u_hpd_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_hpd),
    .o_q   (hpd_s)
  );

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign trigger   = idle_like && (i_start || (hpd_s && !hpd_prev_q));
  assign hpd_lost  = watch_q && !hpd_s;
  assign entry     = cfg_entry(idx_q);
  assign retry_inc = {1'b0, retry_q} + 5'd1;

  // State register and counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      byte_q     <= ST_ADDR;
      settle_q   <= '0;
      gap_q      <= '0;
      retry_q    <= '0;
      idx_q      <= '0;
      watch_q    <= 1'b0;
      abort_q    <= 1'b0;
      hpd_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      settle_q   <= settle_d;
      gap_q      <= gap_d;
      retry_q    <= retry_d;
      idx_q      <= idx_d;
      watch_q    <= watch_d;
      abort_q    <= abort_d;
      hpd_prev_q <= hpd_s;
    end
  end

  // Next-state logic: triggers, settle/gap timing, byte handshakes, retries.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    settle_d = settle_q;
    gap_d    = gap_q;
    retry_d  = retry_q;
    idx_d    = idx_q;
    watch_d  = watch_q;
    abort_d  = abort_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (trigger) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          retry_d  = '0;
          idx_d    = '0;
          watch_d  = hpd_s;
          abort_d  = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (hpd_lost)                   state_d = ST_IDLE;
        else if (settle_q >= SETTLE_LAST) state_d = ST_ADDR;
        else                            settle_d = settle_q + 24'd1;
      end
      ST_ADDR, ST_REG, ST_DATA: begin
        // An offered byte is never withdrawn; remember the loss for later.
        if (hpd_lost) abort_d = 1'b1;
        if (i_cmd_ready) begin
          state_d = ST_WAIT_RSP;
          byte_d  = state_q;
        end
      end
      ST_WAIT_RSP: begin
        if (hpd_lost) abort_d = 1'b1;
        if (i_rsp_valid) begin
          if (abort_q || hpd_lost) begin
            state_d = ST_IDLE;
          end else if (i_rsp_nack) begin
            if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
            if (retry_inc >= {1'b0, RETRY_MAX}) begin
              state_d = ST_ERROR;
            end else begin
              state_d = ST_RETRY_GAP;
              gap_d   = '0;
            end
          end else begin
            case (byte_q)
              ST_ADDR: state_d = ST_REG;
              ST_REG:  state_d = ST_DATA;
              default: begin
                if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
                end else begin
                  state_d = ST_ADDR;
                  idx_d   = idx_q + 6'd1;
                  retry_d = '0;
                end
              end
            endcase
          end
        end
      end
      ST_RETRY_GAP: begin
        if (hpd_lost)            state_d = ST_IDLE;
        else if (gap_q >= GAP_LAST) state_d = ST_ADDR;
        else                     gap_d = gap_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_cmd_valid = 1'b0;
    o_cmd_start = 1'b0;
    o_cmd_stop  = 1'b0;
    o_cmd_data  = '0;
    case (state_q)
      ST_ADDR: begin
        o_cmd_valid = 1'b1;
        o_cmd_start = 1'b1;
        o_cmd_data  = {DEV_ADDR, 1'b0};
      end
      ST_REG: begin
        o_cmd_valid = 1'b1;
        o_cmd_data  = entry[15:8];
      end
      ST_DATA: begin
        o_cmd_valid = 1'b1;
        o_cmd_stop  = 1'b1;
        o_cmd_data  = entry[7:0];
      end
      default: ;
    endcase
    o_busy  = !idle_like;
    o_done  = (state_q == ST_DONE);
    o_error = (state_q == ST_ERROR);
    o_index = idx_q;
  end

endmodule

// File: tb/tb_hdmi_tx_cfg_seq.sv
// Directed testbench for hdmi_tx_cfg_seq with a behavioural I2C master model.
module tb_hdmi_tx_cfg_seq;

  localparam logic [23:0] WAIT_C  = 24'd10;
  localparam logic [15:0] GAP_C   = 16'd20;
  localparam int          NR      = 12;
  localparam int          RSP_LAT = 3;

  logic       clk = 1'b0;
  logic       i_rst, i_start, i_hpd, i_cmd_ready, i_rsp_valid, i_rsp_nack;
  logic       o_cmd_valid, o_cmd_start, o_cmd_stop, o_busy, o_done, o_error;
  logic [7:0] o_cmd_data;
  logic [5:0] o_index;

  logic [7:0] tbl_reg [NR] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2,
                               8'hA3, 8'hE0, 8'hF9, 8'h15, 8'h16, 8'hAF};
  logic [7:0] tbl_val [NR] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4,
                               8'hA4, 8'hD0, 8'h00, 8'h00, 8'h30, 8'h06};

  int n_checks = 0;
  int n_errors = 0;

  // Per-run master plan and results.
  logic [9:0] rec [64];
  int ncmd, first_valid_cyc, end_cyc, last_rsp_cyc, n_retries;
  int nack_idx, nack_pos, nack_left, stall_at, stall_len, drop_idx, rst_at;

  always #5 clk = ~clk;

  hdmi_tx_cfg_seq #(
    .DEV_ADDR    (7'h39),
    .WAIT_CYCLES (WAIT_C),
    .RETRY_MAX   (4'd3),
    .RETRY_GAP   (GAP_C)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_hpd       (i_hpd),
    .o_cmd_valid (o_cmd_valid),
    .o_cmd_start (o_cmd_start),
    .o_cmd_stop  (o_cmd_stop),
    .o_cmd_data  (o_cmd_data),
    .i_cmd_ready (i_cmd_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_nack  (i_rsp_nack),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_index     (o_index)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_plan();
    nack_idx = -1; nack_pos = -1; nack_left = 0;
    stall_at = -1; stall_len = 0; drop_idx = -1; rst_at = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
  endtask

  // Behave as the I2C master for one run, sampling at negedges.
  task automatic run_seq(input int max_cyc, input int busy_cyc);
    int cyc = 0;
    int cd = 0;
    int pos = 0;
    int pend_pos = 0;
    int cur_idx = 0;
    int nack_cyc = 0;
    int stall_left = stall_len;
    logic pend_nack = 1'b0;
    logic acc_prev = 1'b0, acc_now = 1'b0;
    logic ack_prev = 1'b0, ack_now = 1'b0;
    logic valid_prev = 1'b0, retry_wait = 1'b0;
    logic dropped = 1'b0, rst_pend = 1'b0, ended = 1'b0;
    logic [9:0] snap = '0;
    ncmd = 0; first_valid_cyc = -1; end_cyc = -1; last_rsp_cyc = -1; n_retries = 0;
    while (!ended) begin
      @(negedge clk);
      cyc++;
      i_start = 1'b0; i_cmd_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_nack = 1'b0;
      acc_now = 1'b0; ack_now = 1'b0;
      if (cyc == busy_cyc) check_eq("busy_rise", {31'd0, o_busy}, 1);
      if (acc_prev) check_eq("valid_drop", {31'd0, o_cmd_valid}, 0);
      if (ack_prev) check_eq("ack_to_valid", {31'd0, o_cmd_valid}, 1);
      if (o_cmd_valid && !valid_prev) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (retry_wait) begin
          check_eq("retry_gap", cyc - nack_cyc, 32'(GAP_C) + 1);
          check_eq("retry_addr", {o_cmd_start, o_index}, {1'b1, nack_idx[5:0]});
          retry_wait = 1'b0;
          n_retries++;
        end
      end
      valid_prev = o_cmd_valid;
      if (rst_pend) begin
        check_eq("pre_rst_busy", {31'd0, o_busy}, 1);
        i_rst = 1'b1;
        #1;
        check_eq("rst_mid_rsp", {o_cmd_valid, o_cmd_start, o_cmd_stop, o_cmd_data,
                                 o_busy, o_done, o_error, o_index}, 0);
        @(negedge clk);
        i_rst = 1'b0;
        ended = 1'b1;
      end else if (cyc >= busy_cyc && !o_busy) begin
        end_cyc = cyc;
        ended = 1'b1;
      end else if (cyc >= max_cyc) begin
        check_eq("run_timeout", {31'd0, o_busy}, 0);
        ended = 1'b1;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_rsp_valid = 1'b1;
          i_rsp_nack = pend_nack;
          last_rsp_cyc = cyc;
          $display("cmd %0d idx %0d byte %0d data %02h %s", ncmd - 1, cur_idx, pend_pos,
                   rec[ncmd - 1][7:0], pend_nack ? "nack" : "ack");
          if (pend_nack) begin
            nack_cyc = cyc;
            retry_wait = 1'b1;
          end else begin
            ack_now = !dropped && !(pend_pos == 2 && cur_idx == NR - 1);
          end
        end
      end else if (o_cmd_valid) begin
        if (ncmd == stall_at && stall_left > 0) begin
          if (stall_left == stall_len) snap = {o_cmd_start, o_cmd_stop, o_cmd_data};
          else check_eq("stall_hold", {o_cmd_valid, o_cmd_start, o_cmd_stop, o_cmd_data}, {1'b1, snap});
          stall_left--;
        end else begin
          i_cmd_ready = 1'b1;
          pos = o_cmd_start ? 0 : (o_cmd_stop ? 2 : 1);
          cur_idx = int'(o_index);
          pend_pos = pos;
          if (ncmd < 64) rec[ncmd] = {o_cmd_start, o_cmd_stop, o_cmd_data};
          pend_nack = (cur_idx == nack_idx && pos == nack_pos && nack_left > 0);
          if (pend_nack) nack_left--;
          if (pos == 1 && cur_idx == drop_idx) begin
            i_hpd = 1'b0;
            dropped = 1'b1;
          end
          if (ncmd == rst_at) rst_pend = 1'b1;
          ncmd++;
          cd = RSP_LAT;
          acc_now = 1'b1;
        end
      end
      acc_prev = acc_now;
      ack_prev = ack_now;
    end
  endtask

  task automatic check_table();
    for (int i = 0; i < 3 * NR; i++) begin
      int e;
      int p;
      logic [9:0] exp;
      e = i / 3;
      p = i % 3;
      if (p == 0)      exp = {2'b10, 8'h72};
      else if (p == 1) exp = {2'b00, tbl_reg[e]};
      else             exp = {2'b01, tbl_val[e]};
      check_eq($sformatf("tbl%0d", i), {22'd0, rec[i]}, {22'd0, exp});
    end
  endtask

  task automatic check_quiet(input int n);
    int cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (o_cmd_valid || o_busy) cnt++;
    end
    check_eq("quiet", cnt, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_hpd = 1'b0;
    i_cmd_ready = 1'b0; i_rsp_valid = 1'b0; i_rsp_nack = 1'b0;
    clear_plan();
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check_eq("reset_outputs", {o_cmd_valid, o_cmd_start, o_cmd_stop, o_cmd_data,
                               o_busy, o_done, o_error, o_index}, 0);

    // Clean run with a 7-cycle ready stall on the REG byte of entry 1.
    clear_plan(); stall_at = 4; stall_len = 7;
    pulse_start();
    run_seq(3000, 1);
    check_eq("first_valid", first_valid_cyc, 32'(WAIT_C) + 1);
    check_eq("cmd_count", ncmd, 3 * NR);
    check_table();
    check_eq("done_latency", end_cyc, last_rsp_cyc + 1);
    check_eq("done_flags", {o_done, o_error, o_busy}, 3'b100);
    check_quiet(20);

    // REG of entry 4 NACKed twice, then ACKed.
    clear_plan(); nack_idx = 4; nack_pos = 1; nack_left = 2;
    pulse_start();
    run_seq(3000, 1);
    check_eq("retry_count", n_retries, 2);
    check_eq("retry_cmds", ncmd, 3 * NR + 4);
    check_eq("retry_flags", {o_done, o_error, o_busy}, 3'b100);

    // DATA of entry 2 NACKed three times: error.
    clear_plan(); nack_idx = 2; nack_pos = 2; nack_left = 3;
    pulse_start();
    run_seq(3000, 1);
    check_eq("err_retries", n_retries, 2);
    check_eq("err_cmds", ncmd, 15);
    check_eq("err_latency", end_cyc, last_rsp_cyc + 1);
    check_eq("err_flags", {o_done, o_error, o_busy}, 3'b010);
    check_eq("err_index", {26'd0, o_index}, 2);
    check_quiet(40);

    // Rerun from index 0 after the error.
    clear_plan();
    pulse_start();
    run_seq(3000, 1);
    check_eq("rerun_cmds", ncmd, 3 * NR);
    check_table();
    check_eq("rerun_flags", {o_done, o_error, o_busy}, 3'b100);

    // Hot-plug start, then hpd dropped on the REG byte of entry 3.
    clear_plan(); drop_idx = 3;
    @(negedge clk);
    i_hpd = 1'b1;
    run_seq(3000, 3);
    check_eq("hpd_first_valid", first_valid_cyc, 32'(WAIT_C) + 3);
    check_eq("hpd_cmds", ncmd, 11);
    check_eq("hpd_rsp_awaited", end_cyc, last_rsp_cyc + 1);
    check_eq("hpd_flags", {o_done, o_error, o_busy}, 3'b000);
    check_quiet(30);

    // Reset while a response is outstanding.
    clear_plan(); rst_at = 7;
    pulse_start();
    run_seq(3000, 1);
    @(negedge clk);
    check_eq("post_rst_idle", {o_cmd_valid, o_busy, o_done, o_error, o_index}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
